// File: rtl/grid_reader.sv
// Raster sweep of the 16x16 game grid through the second read port.
// Produces body/food counts and the contents of one queried cell per frame.
module grid_reader #(
    parameter int GRID_W  = 16,
    parameter int GRID_H  = 16,
    parameter int COORD_W = 4,
    parameter int DATA_W  = 2,
    parameter int RD_LAT  = 1,
    parameter int CNT_W   = 9
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [COORD_W-1:0] query_x,
    input  logic [COORD_W-1:0] query_y,
    output logic [COORD_W-1:0] x_loc,
    output logic [COORD_W-1:0] y_loc,
    output logic               rd_en,
    input  logic [DATA_W-1:0]  data_in,
    output logic               busy,
    output logic               done,
    output logic [DATA_W-1:0]  query_data,
    output logic               hit_body,
    output logic               hit_food,
    output logic               hit_wall,
    output logic [CNT_W-1:0]   body_count,
    output logic [CNT_W-1:0]   food_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SCAN  = 2'b01,
        DRAIN = 2'b10,
        DONE  = 2'b11
    } state_t;

    localparam logic [COORD_W-1:0] X_MAX      = COORD_W'(GRID_W - 1);
    localparam logic [COORD_W-1:0] Y_MAX      = COORD_W'(GRID_H - 1);
    localparam logic [COORD_W:0]   W_LIMIT    = (COORD_W + 1)'(GRID_W);
    localparam logic [COORD_W:0]   H_LIMIT    = (COORD_W + 1)'(GRID_H);
    localparam logic [1:0]         DRAIN_LAST = 2'(RD_LAT - 1);

    localparam logic [DATA_W-1:0]  CELL_BODY  = DATA_W'(1);
    localparam logic [DATA_W-1:0]  CELL_FOOD  = DATA_W'(2);
    localparam logic [DATA_W-1:0]  CELL_WALL  = DATA_W'(3);

    state_t              state_r;
    state_t              state_s;
    logic [1:0]          drain_cnt_r;
    logic [COORD_W-1:0]  qx_r;
    logic [COORD_W-1:0]  qy_r;
    logic                oor_r;
    logic                accept_s;
    logic                last_addr_s;
    logic                match_s;

    logic                v_pipe_r [RD_LAT];
    logic [COORD_W-1:0]  x_pipe_r [RD_LAT];
    logic [COORD_W-1:0]  y_pipe_r [RD_LAT];

    assign accept_s    = (state_r == IDLE) && start;
    assign last_addr_s = (x_loc == X_MAX) && (y_loc == Y_MAX);
    assign match_s     = (x_pipe_r[RD_LAT-1] == qx_r) && (y_pipe_r[RD_LAT-1] == qy_r) && !oor_r;

    // Next-state logic for the sweep sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) state_s = SCAN;
                else       state_s = IDLE;
            end
            SCAN: begin
                if (last_addr_s) state_s = DRAIN;
                else             state_s = SCAN;
            end
            DRAIN: begin
                if (drain_cnt_r == DRAIN_LAST) state_s = DONE;
                else                           state_s = DRAIN;
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register, drain counter and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            drain_cnt_r <= 2'd0;
            rd_en       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_r     <= state_s;
            drain_cnt_r <= (state_r == DRAIN) ? drain_cnt_r + 2'd1 : 2'd0;
            rd_en       <= (state_s == SCAN);
            busy        <= (state_s == SCAN) || (state_s == DRAIN);
            done        <= (state_s == DONE);
        end
    end

    // Raster address generator; the address holds its value outside SCAN.
    always_ff @(posedge clk) begin
        if (reset) begin
            x_loc <= '0;
            y_loc <= '0;
        end else if (accept_s) begin
            x_loc <= '0;
            y_loc <= '0;
        end else if ((state_r == SCAN) && !last_addr_s) begin
            if (x_loc == X_MAX) begin
                x_loc <= '0;
                y_loc <= y_loc + COORD_W'(1);
            end else begin
                x_loc <= x_loc + COORD_W'(1);
            end
        end
    end

    // Valid/coordinate pipeline matching the memory read latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < RD_LAT; i++) begin
                v_pipe_r[i] <= 1'b0;
                x_pipe_r[i] <= '0;
                y_pipe_r[i] <= '0;
            end
        end else begin
            v_pipe_r[0] <= rd_en;
            x_pipe_r[0] <= x_loc;
            y_pipe_r[0] <= y_loc;
            for (int i = 1; i < RD_LAT; i++) begin
                v_pipe_r[i] <= v_pipe_r[i-1];
                x_pipe_r[i] <= x_pipe_r[i-1];
                y_pipe_r[i] <= y_pipe_r[i-1];
            end
        end
    end

    // Query latch, counters and hit capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            qx_r       <= '0;
            qy_r       <= '0;
            oor_r      <= 1'b0;
            body_count <= '0;
            food_count <= '0;
            query_data <= '0;
            hit_body   <= 1'b0;
            hit_food   <= 1'b0;
            hit_wall   <= 1'b0;
        end else if (accept_s) begin
            qx_r       <= query_x;
            qy_r       <= query_y;
            oor_r      <= ({1'b0, query_x} >= W_LIMIT) || ({1'b0, query_y} >= H_LIMIT);
            body_count <= '0;
            food_count <= '0;
            query_data <= '0;
            hit_body   <= 1'b0;
            hit_food   <= 1'b0;
            hit_wall   <= 1'b0;
        end else begin
            if (v_pipe_r[RD_LAT-1]) begin
                if (data_in == CELL_BODY) body_count <= body_count + CNT_W'(1);
                if (data_in == CELL_FOOD) food_count <= food_count + CNT_W'(1);
                if (match_s) begin
                    query_data <= data_in;
                    hit_body   <= (data_in == CELL_BODY);
                    hit_food   <= (data_in == CELL_FOOD);
                    hit_wall   <= (data_in == CELL_WALL);
                end
            end
            // An off-grid query reads as wall once the frame completes.
            if ((state_r == DRAIN) && (state_s == DONE) && oor_r) begin
                query_data <= CELL_WALL;
                hit_wall   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_grid_reader.sv
// Directed bench for grid_reader: two instances (read latency 1 and 3) share
// stimulus and each has its own behavioural memory model.
module tb_grid_reader;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] query_x;
    logic [3:0] query_y;

    logic [3:0] x1, y1, x3, y3;
    logic       rd1, rd3, busy1, busy3, done1, done3;
    logic       hb1, hf1, hw1, hb3, hf3, hw3;
    logic [1:0] qd1, qd3, data1, data3;
    logic [8:0] bc1, fc1, bc3, fc3;

    logic [1:0] mem [16][16];
    logic [1:0] s3a, s3b;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int pat;
        int qx;
        int qy;
        int body;
        int food;
        int hb;
        int hf;
        int hw;
        int qd;
    } vec_t;

    vec_t vecs [7];

    always #5 clk = ~clk;

    grid_reader #(.RD_LAT(1)) dut1 (
        .clk(clk), .reset(reset), .start(start), .query_x(query_x), .query_y(query_y),
        .x_loc(x1), .y_loc(y1), .rd_en(rd1), .data_in(data1), .busy(busy1), .done(done1),
        .query_data(qd1), .hit_body(hb1), .hit_food(hf1), .hit_wall(hw1),
        .body_count(bc1), .food_count(fc1)
    );

    grid_reader #(.RD_LAT(3)) dut3 (
        .clk(clk), .reset(reset), .start(start), .query_x(query_x), .query_y(query_y),
        .x_loc(x3), .y_loc(y3), .rd_en(rd3), .data_in(data3), .busy(busy3), .done(done3),
        .query_data(qd3), .hit_body(hb3), .hit_food(hf3), .hit_wall(hw3),
        .body_count(bc3), .food_count(fc3)
    );

    // Memory models; idle cycles return wall data that must be ignored.
    always @(posedge clk) begin
        data1 <= rd1 ? mem[y1][x1] : 2'b11;
        s3a   <= rd3 ? mem[y3][x3] : 2'b11;
        s3b   <= s3a;
        data3 <= s3b;
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic fill_mem(input int pat);
        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 16; x++) begin
                mem[y][x] = 2'b00;
                if (pat == 2 && (x == 0 || x == 15 || y == 0 || y == 15)) mem[y][x] = 2'b11;
            end
        if (pat == 1) begin
            mem[5][5] = 2'b01;
            mem[5][6] = 2'b01;
            mem[5][7] = 2'b01;
            mem[9][2] = 2'b10;
        end
        if (pat == 3) mem[15][15] = 2'b01;
    endtask

    task automatic check_results(input string tag, input vec_t v);
        chk({tag, " body1"}, int'(bc1), v.body);
        chk({tag, " food1"}, int'(fc1), v.food);
        chk({tag, " flags1"}, int'({hb1, hf1, hw1}), v.hb * 4 + v.hf * 2 + v.hw);
        chk({tag, " qdata1"}, int'(qd1), v.qd);
        chk({tag, " body3"}, int'(bc3), v.body);
        chk({tag, " food3"}, int'(fc3), v.food);
        chk({tag, " flags3"}, int'({hb3, hf3, hw3}), v.hb * 4 + v.hf * 2 + v.hw);
        chk({tag, " qdata3"}, int'(qd3), v.qd);
    endtask

    // Full sweep; optional extra start pulses at T+10 and T+100 must be ignored.
    task automatic run_sweep(input vec_t v, input bit extra);
        int  rdc1, rdc3, dn1, dn3, dc1, dc3;
        bit  addr_ok, busy_ok;
        rdc1 = 0; rdc3 = 0; dn1 = -1; dn3 = -1; dc1 = 0; dc3 = 0;
        addr_ok = 1'b1; busy_ok = 1'b1;
        fill_mem(v.pat);
        @(posedge clk); #1;
        start = 1'b1; query_x = 4'(v.qx); query_y = 4'(v.qy);
        for (int n = 1; n <= 262; n++) begin
            @(posedge clk); #1;
            start = extra && (n == 10 || n == 100);
            if (start) begin query_x = 4'd0; query_y = 4'd0; end
            if (rd1) begin
                rdc1++;
                if (n > 256 || int'(x1) != (n - 1) % 16 || int'(y1) != (n - 1) / 16) addr_ok = 1'b0;
            end
            if (rd3) begin
                rdc3++;
                if (n > 256 || int'(x3) != (n - 1) % 16 || int'(y3) != (n - 1) / 16) addr_ok = 1'b0;
            end
            if (busy1 != (n <= 257)) busy_ok = 1'b0;
            if (busy3 != (n <= 259)) busy_ok = 1'b0;
            if (done1) begin dc1++; dn1 = n; end
            if (done3) begin dc3++; dn3 = n; end
        end
        chk("rd_en cycles lat1", rdc1, 256);
        chk("rd_en cycles lat3", rdc3, 256);
        chk("raster addresses", int'(addr_ok), 1);
        chk("busy window", int'(busy_ok), 1);
        chk("done count lat1", dc1, 1);
        chk("done count lat3", dc3, 1);
        chk("done cycle lat1", dn1, 258);
        chk("done cycle lat3", dn3, 260);
        check_results(extra ? "restarted" : "sweep", v);
    endtask

    initial begin
        vec_t rv;
        int   n;
        int   dcount;

        //           pat qx qy body food hb hf hw qd
        vecs[0] = '{0,  3,  4, 0,   0,   0, 0, 0, 0};
        vecs[1] = '{1,  6,  5, 3,   1,   1, 0, 0, 1};
        vecs[2] = '{1,  2,  9, 3,   1,   0, 1, 0, 2};
        vecs[3] = '{2,  0,  7, 0,   0,   0, 0, 1, 3};
        vecs[4] = '{2, 15, 15, 0,   0,   0, 0, 1, 3};
        vecs[5] = '{3, 15, 15, 1,   0,   1, 0, 0, 1};
        vecs[6] = '{1,  5,  6, 3,   1,   0, 0, 0, 0};

        reset = 1'b1; start = 1'b0; query_x = 4'd0; query_y = 4'd0;
        fill_mem(0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset outputs lat1", int'({busy1, done1, rd1, hb1, hf1, hw1, qd1, bc1, fc1, x1, y1}), 0);
        chk("reset outputs lat3", int'({busy3, done3, rd3, hb3, hf3, hw3, qd3, bc3, fc3, x3, y3}), 0);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) run_sweep(vecs[i], 1'b0);

        // Start pulses during SCAN are ignored.
        run_sweep(vecs[1], 1'b1);

        // Start on the cycle after done begins a fresh sweep.
        fill_mem(1);
        @(posedge clk); #1;
        start = 1'b1; query_x = 4'd6; query_y = 4'd5;
        n = 0;
        do begin
            @(posedge clk); #1;
            start = 1'b0;
            n++;
        end while (!done1 && n < 300);
        chk("done cycle before restart", n, 258);
        @(posedge clk); #1;
        start = 1'b1; query_x = 4'd2; query_y = 4'd9;
        @(posedge clk); #1;
        start = 1'b0;
        chk("restart addr", int'({rd1, busy1, x1, y1}), 3 << 8);
        chk("restart counts cleared", int'({bc1, fc1}), 0);
        chk("lat3 ignores start in drain", int'(done3), 1);
        repeat (270) @(posedge clk);
        #1;
        chk("restart body", int'(bc1), 3);
        chk("restart food hit", int'({hf1, qd1}), 6);

        // Synchronous reset mid-sweep aborts without a done pulse.
        fill_mem(1);
        @(posedge clk); #1;
        start = 1'b1; query_x = 4'd6; query_y = 4'd5;
        for (int k = 1; k <= 120; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            reset = (k == 120);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort lat1", int'({busy1, rd1, done1, bc1, fc1, hb1}), 0);
        chk("abort lat3", int'({busy3, rd3, done3, bc3, fc3, hb3}), 0);
        dcount = 0;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk); #1;
            if (done1 || done3) dcount++;
        end
        chk("no done after abort", dcount, 0);
        rv = vecs[1];
        run_sweep(rv, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/grid_reader.md
Name: grid_reader

Overview:
- Sweeps the 16x16 game-grid memory in raster order through its second read port and returns a summary of the current frame.
- Reports whether a queried cell, normally the snake's next head position, holds body, food or wall. Reports total body and food cell counts.
- Sits beside the cell writer on the game-logic clock domain. The writer fills the grid; this block reads it back so the game logic can detect collisions and eating.
- Cell encoding: 2'b00 empty, 2'b01 body, 2'b10 food, 2'b11 wall.

Parameters:
GRID_W, 16, grid columns
GRID_H, 16, grid rows
COORD_W, 4, coordinate width
DATA_W, 2, cell data width
RD_LAT, 1, memory read latency in clk cycles (1..3)
CNT_W, 9, width of the cell counters; must hold GRID_W*GRID_H

Ports:
clk  input  1  system clock
reset  input  1  reset, synchronous, active-high
start  input  1  one-cycle request to begin a sweep
query_x  input  COORD_W  column to test, sampled with start
query_y  input  COORD_W  row to test, sampled with start
x_loc  output  COORD_W  read address, column
y_loc  output  COORD_W  read address, row
rd_en  output  1  read address valid
data_in  input  DATA_W  memory read data, RD_LAT cycles after address
busy  output  1  sweep in progress
done  output  1  one-cycle pulse; results valid from this cycle
query_data  output  DATA_W  cell value at the query coordinate
hit_body  output  1  query cell == 01
hit_food  output  1  query cell == 10
hit_wall  output  1  query cell == 11, or query out of range
body_count  output  CNT_W  number of 01 cells
food_count  output  CNT_W  number of 10 cells

Behaviour:
- Reset state: all outputs 0 and FSM in IDLE. Reset mid-sweep aborts immediately; no done pulse follows.
- FSM states and transitions:
  - IDLE -> SCAN on start.
  - SCAN -> DRAIN after the address (GRID_W-1, GRID_H-1) is issued.
  - DRAIN -> DONE after RD_LAT cycles.
  - DONE -> IDLE after one cycle.
- Start handling:
  - start is honoured only in IDLE; it is ignored in SCAN, DRAIN and DONE.
  - When start is sampled at cycle T: the query coordinates are latched, and all result outputs and counters clear to 0 at T+1.
- Addressing:
  - Raster order, x fastest. (0,0) is issued at T+1 and (GRID_W-1,GRID_H-1) at T+GRID_W*GRID_H.
  - x wraps GRID_W-1 -> 0 with y+1.
  - One address per cycle; rd_en=1 throughout SCAN and 0 otherwise.
  - x_loc and y_loc hold their last value outside SCAN.
- Read pipeline:
  - A RD_LAT-deep shift pipeline carries valid, x and y alongside each read.
  - data_in is consumed only when the delayed valid is 1.
- Accumulation:
  - 01 increments body_count; 10 increments food_count.
  - When the delayed x,y equals the latched query, data_in is captured into query_data and the hit flags.
- Out-of-range query (query_x>=GRID_W or query_y>=GRID_H):
  - hit_wall=1 and query_data=2'b11, set at done.
  - Memory data never matches the query in this case.
- Timing for a 16x16 grid:
  - busy=1 from T+1 through T+256+RD_LAT.
  - done=1 at T+257+RD_LAT only.
  - With RD_LAT=1, done is at T+258.
- Results hold after done until the next accepted start or reset.
- Start is accepted again on the cycle after done (IDLE).
- Counter width: the counters never overflow because CNT_W holds 256. Arithmetic is unsigned, with no saturation logic needed.
- Data_in is ignored whenever the delayed valid is 0.

Test Plan:
- Memory model all 00, start at T with query (3,4), RD_LAT=1 -> 256 consecutive rd_en cycles; done at T+258; body_count=0, food_count=0, all hit flags 0, query_data=00.
- Memory with body at (5,5),(6,5),(7,5), food at (2,9), query (6,5) -> body_count=3, food_count=1, hit_body=1, hit_food=0, query_data=01. Repeat with query (2,9) -> hit_food=1.
- Full wall border (60 cells =11), query (0,7) -> hit_wall=1, body_count=0. Query (15,15) -> hit_wall=1. Addresses observed: (15,0) followed by (0,1) at wrap.
- Pulse start again at T+10 and T+100 during the sweep -> both ignored; a single done at T+258; the results match the single-start case. Start at T+259 -> a new sweep begins with x_loc=0,y_loc=0 at T+260.
- Assert reset at T+120 mid-sweep -> at T+121 busy=0, rd_en=0, counts 0, and no done within the following 300 cycles. A new start then completes normally.
- RD_LAT=3, body at (15,15) only, query (15,15) -> done at T+260; body_count=1, hit_body=1. Verifies the last cell survives the drain phase.
